// File: rtl/serial_word_collector.sv
// Reassembles an MSB-first serial bit stream into WIDTH-bit words and queues them in a DEPTH-entry FIFO.
// Word visible one cycle after its last bit; bitReady drops only when the FIFO is full and one bit from completion.
module serial_word_collector #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                      c,
  input  logic                      r,
  input  logic                      bitIn,
  input  logic                      bitValid,
  input  logic                      flush,
  output logic                      bitReady,
  output logic [WIDTH-1:0]          wordOut,
  output logic                      wordValid,
  input  logic                      wordReady,
  output logic [$clog2(WIDTH)-1:0]  partialCount,
  output logic                      overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  logic [WIDTH-2:0] asm_q, asm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             full, empty, last, accept, complete, pop, push;
  logic [WIDTH-1:0] new_word;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = (occ_q == OCC_FULL);
    empty    = (occ_q == '0);
    last     = (cnt_q == LAST);
    accept   = bitValid & ~flush;
    complete = accept & last;
    pop      = wordReady & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO can still take the word.
    push     = complete & (~full | pop);
    new_word = {asm_q, bitIn};

    asm_d    = asm_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;

    if (flush) begin
      asm_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (last) begin
        asm_d = '0;
        cnt_d = '0;
      end else begin
        asm_d = new_word[WIDTH-2:0];
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (pop)  rd_ptr_d = nxt_ptr(rd_ptr_q);
    if (push) wr_ptr_d = nxt_ptr(wr_ptr_q);
    if (push && !pop)      occ_d = occ_q + OW'(1);
    else if (pop && !push) occ_d = occ_q - OW'(1);

    if (complete && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge c) begin
    if (r) begin
      asm_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      if (push) mem_q[wr_ptr_q] <= new_word;
    end
  end

  assign wordValid    = ~empty;
  assign wordOut      = empty ? '0 : mem_q[rd_ptr_q];
  assign partialCount = cnt_q;
  assign overflow     = ovf_q;
  assign bitReady     = ~(full & last);

endmodule
